// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types for the data-memory arbiter: sequencer states, requester
//   ids, RV32I load/store funct3 codes, the latched request record and the
//   command-fault classifier used when misalignment checking is built in.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } owner_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
        logic [2:0]             funct3;
    } req_t;

    // A command faults on an encoding the access kind does not support, or
    // on a halfword/word access that is not naturally aligned. funct3[1:0]
    // gives the size for both loads and stores (01 = half, 10 = word).
    function automatic logic cmd_faults(input req_t cmd);
        logic bad_f3;
        logic bad_align;
        if (cmd.we) begin
            bad_f3 = !(cmd.funct3 inside {F3_SB, F3_SH, F3_SW});
        end else begin
            bad_f3 = !(cmd.funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end
        bad_align = ((cmd.funct3[1:0] == 2'b01) && cmd.addr[0]) ||
                    ((cmd.funct3[1:0] == 2'b10) && (cmd.addr[1:0] != 2'b00));
        return bad_f3 || bad_align;
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter
//   Pure combinational two-way round-robin grant. The priority pointer is
//   owned by the parent, which advances it after each grant.
// Ports:
//   en       in   grants allowed this cycle
//   c_valid  in   port C requesting
//   d_valid  in   port D requesting
//   prio     in   port that wins a tie
//   grant    out  one-hot grant, bit 0 = C, bit 1 = D
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
(
    input  logic       en,
    input  logic       c_valid,
    input  logic       d_valid,
    input  owner_e     prio,
    output logic [1:0] grant
);

    // NOTE: every output of a combinational block gets a default on entry,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (c_valid && d_valid) begin
                grant = (prio == PORT_D) ? 2'b10 : 2'b01;
            end else begin
                grant = {d_valid, c_valid};
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-ported data memory between the CPU load/store port (C)
//   and the boot-loader/DMA port (D). Each grant runs accept -> access ->
//   respond; the response is registered and held until the owner takes it.
// Build option:
//   DMEM_ARB_MISALIGN_CHECK_EN  classify each accepted command; faulting
//                               commands skip memory and respond with err.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   {c,d}_req_*              request channel (valid/ready, we, addr, wdata, funct3)
//   {c,d}_rsp_*              response channel (valid/ready, rdata, err)
//   mem_wr, mem_read         memory strobes, only in the access cycle
//   mem_addr/wdata/funct3    latched command presented to memory
//   mem_rdata                combinational read data from memory
//   busy                     sequencer not idle
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic              c_req_we,
    input  logic [ADDR_W-1:0] c_req_addr,
    input  logic [31:0]       c_req_wdata,
    input  logic [2:0]        c_req_funct3,
    output logic              c_rsp_valid,
    input  logic              c_rsp_ready,
    output logic [31:0]       c_rsp_rdata,
    output logic              c_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    input  logic [2:0]        d_req_funct3,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [31:0]       d_rsp_rdata,
    output logic              d_rsp_err,
    output logic              mem_wr,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    state_e      state_q, state_d;
    owner_e      prio_q, prio_d;
    owner_e      owner_q, owner_d;
    req_t        cmd_q, cmd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  grant;
    req_t        c_cmd, d_cmd, win_cmd;
    logic        owner_rsp_ready;
    logic        access_ok;
    logic        rsp_active;

    assign c_cmd = '{we: c_req_we, addr: c_req_addr, wdata: c_req_wdata, funct3: c_req_funct3};
    assign d_cmd = '{we: d_req_we, addr: d_req_addr, wdata: d_req_wdata, funct3: d_req_funct3};

    dmem_rr_arbiter u_rr (
        .en      ((state_q == IDLE) && !rst),
        .c_valid (c_req_valid),
        .d_valid (d_req_valid),
        .prio    (prio_q),
        .grant   (grant)
    );

    assign owner_rsp_ready = (owner_q == PORT_D) ? d_rsp_ready : c_rsp_ready;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        win_cmd = grant[1] ? d_cmd : c_cmd;
        unique case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    owner_d = grant[1] ? PORT_D : PORT_C;
                    // The loser of this grant wins the next tie.
                    prio_d  = grant[1] ? PORT_C : PORT_D;
                    cmd_d   = win_cmd;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
                    err_d   = cmd_faults(win_cmd);
`else
                    err_d   = 1'b0;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Stores and rejected commands answer with zero data.
                rdata_d = (cmd_q.we || err_q) ? 32'h0 : mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= PORT_C;
            owner_q <= PORT_C;
            cmd_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: reset is synchronous for the state, but it also gates every
    // output directly so a reset landing on the access cycle cannot let a
    // store strobe reach memory.
    assign access_ok   = !rst && (state_q == ACCESS) && !err_q;
    assign mem_wr      = access_ok && cmd_q.we;
    assign mem_read    = access_ok && !cmd_q.we;
    assign mem_addr    = rst ? '0 : cmd_q.addr;
    assign mem_wdata   = rst ? 32'h0 : cmd_q.wdata;
    assign mem_funct3  = rst ? 3'b000 : cmd_q.funct3;

    assign c_req_ready = grant[0];
    assign d_req_ready = grant[1];

    assign rsp_active  = !rst && (state_q == RESP);
    assign c_rsp_valid = rsp_active && (owner_q == PORT_C);
    assign d_rsp_valid = rsp_active && (owner_q == PORT_D);
    assign c_rsp_rdata = c_rsp_valid ? rdata_q : 32'h0;
    assign d_rsp_rdata = d_rsp_valid ? rdata_q : 32'h0;
    assign c_rsp_err   = c_rsp_valid && err_q;
    assign d_rsp_err   = d_rsp_valid && err_q;

    assign busy        = !rst && (state_q != IDLE);

endmodule
